rst_seq_gen: RTL and testbench

Parametrised single-clock reset sequencer generating NUM_OUT staggered interconnect resets plus a peripheral reset. It sits beside the clock map, replacing chained fixed reset cores. It merges external, auxiliary, clock-locked and software reset sources, enforces a minimum assertion width, and releases outputs in index order with a programmable gap. It also records which source caused the last reset.

---
 rtl/rst_seq_gen.sv | 233 +++++++++++++++++++++++
 tb/tb_rst_seq_gen.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_gen.sv
// rst_seq_gen
//
// Single-clock reset sequencer. It merges four reset sources into one
// trigger: external, auxiliary, clock-locked and software. It holds every
// reset output low for a minimum number of trigger-free cycles. It then
// releases the interconnect resets in index order, one every STAGE_GAP
// cycles, and releases the peripheral reset last. A sticky cause register
// records which sources have requested a reset since it was last cleared.
//
// Parameters
//   NUM_OUT      number of interconnect reset outputs (1..8)
//   SYNC_STAGES  synchroniser depth for ext/aux/locked inputs (>= 2)
//   MIN_ASSERT   trigger-free cycles required before the first release (>= 1)
//   STAGE_GAP    cycles between successive releases (>= 1)
//
// Ports
//   aclk                  sole clock
//   aresetn               asynchronous active-low power-on reset
//   ext_resetn            async external reset request, active-low
//   aux_resetn            async auxiliary reset request, active-low
//   dcm_locked            async clock-locked status, low requests reset
//   sw_reset              aclk-synchronous single-cycle request, active-high
//   cause_clr             aclk-synchronous pulse that clears cause
//   interconnect_aresetn  staged active-low resets, index 0 released first
//   peripheral_aresetn    active-low reset, released after all interconnect
//   ready                 high once every reset output is released
//   cause                 sticky {por, sw, locked, aux, ext}
//
// All outputs are registered.

module rst_seq_gen #(
  parameter int NUM_OUT     = 3,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_ASSERT  = 16,
  parameter int STAGE_GAP   = 4
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               ext_resetn,
  input  logic               aux_resetn,
  input  logic               dcm_locked,
  input  logic               sw_reset,
  input  logic               cause_clr,
  output logic [NUM_OUT-1:0] interconnect_aresetn,
  output logic               peripheral_aresetn,
  output logic               ready,
  output logic [4:0]         cause
);

  // The counter must hold the larger of the two terminal counts without
  // wrapping.
  localparam int CNT_MAX = (MIN_ASSERT > STAGE_GAP) ? MIN_ASSERT : STAGE_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]      ASSERT_LAST = CW'(MIN_ASSERT - 1);
  localparam logic [CW-1:0]      GAP_LAST    = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0]      CNT_ONE     = CW'(1);
  localparam logic [NUM_OUT-1:0] FIRST_OUT   = NUM_OUT'(1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  // --------------------------------------------------------------------
  // Input synchronisers
  // --------------------------------------------------------------------
  // The flops reset to 0, so each active-low request reads as asserted
  // until a 1 has travelled through the chain. fill_sync runs alongside
  // the chains and marks when their outputs reflect real input values.
  logic [SYNC_STAGES-1:0] ext_sync;
  logic [SYNC_STAGES-1:0] aux_sync;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic [SYNC_STAGES-1:0] fill_sync;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ext_sync  <= '0;
      aux_sync  <= '0;
      lock_sync <= '0;
      fill_sync <= '0;
    end else begin
      ext_sync  <= {ext_sync[SYNC_STAGES-2:0], ext_resetn};
      aux_sync  <= {aux_sync[SYNC_STAGES-2:0], aux_resetn};
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], dcm_locked};
      fill_sync <= {fill_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  logic ext_s;
  logic aux_s;
  logic lock_s;
  logic primed;

  assign ext_s  = ext_sync[SYNC_STAGES-1];
  assign aux_s  = aux_sync[SYNC_STAGES-1];
  assign lock_s = lock_sync[SYNC_STAGES-1];
  assign primed = fill_sync[SYNC_STAGES-1];

  // The zero-fill still holds the sequencer in reset. It is not recorded
  // as a source, so a clean power-on reports por only. A source that is
  // still held active once the chain has filled is recorded as usual.
  logic trigger;
  logic [4:0] src;

  assign trigger = ~ext_s | ~aux_s | ~lock_s | sw_reset;
  assign src     = {1'b0, sw_reset, primed & ~lock_s,
                    primed & ~aux_s, primed & ~ext_s};

  // --------------------------------------------------------------------
  // Cause register
  // --------------------------------------------------------------------
  // A source active on the clearing edge survives the clear.
  logic [4:0] cause_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cause_q <= 5'b10000;
    end else if (cause_clr) begin
      cause_q <= src;
    end else begin
      cause_q <= cause_q | src;
    end
  end

  assign cause = cause_q;

  // --------------------------------------------------------------------
  // Sequencer FSM
  // --------------------------------------------------------------------
  // icn_q is a thermometer code: the released interconnect outputs are
  // always a contiguous run from index 0. A new output is released by
  // shifting in a 1. Once the code is all ones, the next gap releases the
  // peripheral reset.
  state_t              state_q;
  state_t              state_d;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_d;
  logic [NUM_OUT-1:0]  icn_q;
  logic [NUM_OUT-1:0]  icn_d;
  logic                per_q;
  logic                per_d;
  logic                rdy_q;
  logic                rdy_d;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      icn_q   <= '0;
      per_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      icn_q   <= icn_d;
      per_q   <= per_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    icn_d   = icn_q;
    per_d   = per_q;
    rdy_d   = rdy_q;

    case (state_q)
      ST_ASSERT: begin
        icn_d = '0;
        per_d = 1'b0;
        rdy_d = 1'b0;
        if (trigger) begin
          // Any request restarts the minimum-assertion window.
          cnt_d = '0;
        end else if (cnt_q == ASSERT_LAST) begin
          cnt_d   = '0;
          icn_d   = FIRST_OUT;
          state_d = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_RELEASE: begin
        if (trigger) begin
          // No partial hold: everything drops and release restarts at 0.
          cnt_d   = '0;
          icn_d   = '0;
          per_d   = 1'b0;
          rdy_d   = 1'b0;
          state_d = ST_ASSERT;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (&icn_q) begin
            per_d   = 1'b1;
            rdy_d   = 1'b1;
            state_d = ST_RUN;
          end else begin
            icn_d = (icn_q << 1) | FIRST_OUT;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_RUN: begin
        cnt_d = '0;
        if (trigger) begin
          icn_d   = '0;
          per_d   = 1'b0;
          rdy_d   = 1'b0;
          state_d = ST_ASSERT;
        end
      end

      default: begin
        cnt_d   = '0;
        icn_d   = '0;
        per_d   = 1'b0;
        rdy_d   = 1'b0;
        state_d = ST_ASSERT;
      end
    endcase
  end

  assign interconnect_aresetn = icn_q;
  assign peripheral_aresetn   = per_q;
  assign ready                = rdy_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Testbench for rst_seq_gen.
//
// Two independent sources of expected values:
//  - hand-written tables of {stimulus, expected outputs} at specific edges
//    (edge 1 = first rising edge after aresetn is released);
//  - a reference model that is checked on every edge. The model tracks
//    "consecutive trigger-free edges" and derives each output from a
//    threshold on that number.

module tb_rst_seq_gen;

  localparam int NUM_OUT     = 3;
  localparam int SYNC_STAGES = 2;
  localparam int MIN_ASSERT  = 16;
  localparam int STAGE_GAP   = 4;

  logic               clk;
  logic               aresetn;
  logic               ext_resetn;
  logic               aux_resetn;
  logic               dcm_locked;
  logic               sw_reset;
  logic               cause_clr;
  logic [NUM_OUT-1:0] icn;
  logic               per;
  logic               rdy;
  logic [4:0]         cause;

  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;

  rst_seq_gen #(
    .NUM_OUT    (NUM_OUT),
    .SYNC_STAGES(SYNC_STAGES),
    .MIN_ASSERT (MIN_ASSERT),
    .STAGE_GAP  (STAGE_GAP)
  ) dut (
    .aclk                (clk),
    .aresetn             (aresetn),
    .ext_resetn          (ext_resetn),
    .aux_resetn          (aux_resetn),
    .dcm_locked          (dcm_locked),
    .sw_reset            (sw_reset),
    .cause_clr           (cause_clr),
    .interconnect_aresetn(icn),
    .peripheral_aresetn  (per),
    .ready               (rdy),
    .cause               (cause)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // quiet = number of consecutive edges without any request.
  // Output k is released once quiet >= MIN_ASSERT + k*STAGE_GAP; the
  // peripheral reset and ready once quiet >= MIN_ASSERT + NUM_OUT*STAGE_GAP.
  // Async requests are seen SYNC_STAGES edges after being sampled; before
  // that many samples exist they read as asserted, but are not recorded.
  int         m_quiet;
  logic [4:0] m_cause;
  logic       ext_h[$];
  logic       aux_h[$];
  logic       lck_h[$];

  task automatic model_reset();
    m_quiet = 0;
    m_cause = 5'b10000;
    ext_h.delete();
    aux_h.delete();
    lck_h.delete();
  endtask

  task automatic model_edge();
    logic primed, e_v, a_v, l_v, trig;
    logic [4:0] srcs;
    primed = (ext_h.size() == SYNC_STAGES);
    e_v = primed ? ext_h[0] : 1'b0;
    a_v = primed ? aux_h[0] : 1'b0;
    l_v = primed ? lck_h[0] : 1'b0;
    trig = !e_v || !a_v || !l_v || sw_reset;
    srcs = {1'b0, sw_reset, primed && !l_v, primed && !a_v, primed && !e_v};
    m_cause = cause_clr ? srcs : (m_cause | srcs);
    if (trig) m_quiet = 0;
    else if (m_quiet < 100000) m_quiet = m_quiet + 1;
    ext_h.push_back(ext_resetn);
    aux_h.push_back(aux_resetn);
    lck_h.push_back(dcm_locked);
    if (ext_h.size() > SYNC_STAGES) begin
      void'(ext_h.pop_front());
      void'(aux_h.pop_front());
      void'(lck_h.pop_front());
    end
  endtask

  // One clock edge: update the model from the inputs at the edge, then
  // compare DUT outputs 1 time unit later.
  task automatic do_edge();
    logic [NUM_OUT-1:0] m_icn;
    logic m_done;
    @(posedge clk);
    model_edge();
    edge_cnt++;
    #1;
    for (int k = 0; k < NUM_OUT; k++)
      m_icn[k] = (m_quiet >= MIN_ASSERT + k * STAGE_GAP);
    m_done = (m_quiet >= MIN_ASSERT + NUM_OUT * STAGE_GAP);
    check($sformatf("model icn e%0d", edge_cnt), 8'(icn), 8'(m_icn));
    check($sformatf("model per e%0d", edge_cnt), 8'(per), 8'(m_done));
    check($sformatf("model rdy e%0d", edge_cnt), 8'(rdy), 8'(m_done));
    check($sformatf("model cause e%0d", edge_cnt), 8'(cause), 8'(m_cause));
  endtask

  // ---------------- table runner ----------------
  // stim = {ext_resetn, aux_resetn, dcm_locked, sw_reset, cause_clr},
  // applied before edge_n and held until changed; expectations after edge_n.
  typedef struct {
    int                 edge_n;
    logic [4:0]         stim;
    logic [NUM_OUT-1:0] icn;
    logic               per;
    logic               rdy;
    logic [4:0]         cause;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(int e, logic [4:0] s, logic [NUM_OUT-1:0] i,
                              logic p, logic r, logic [4:0] c);
    vec_t v;
    v.edge_n = e; v.stim = s; v.icn = i; v.per = p; v.rdy = r; v.cause = c;
    tbl.push_back(v);
  endfunction

  task automatic run_tbl(input string tag, input int last);
    for (int e = 1; e <= last; e++) begin
      foreach (tbl[i])
        if (tbl[i].edge_n == e)
          {ext_resetn, aux_resetn, dcm_locked, sw_reset, cause_clr} = tbl[i].stim;
      do_edge();
      foreach (tbl[i])
        if (tbl[i].edge_n == e) begin
          check($sformatf("%s e%0d icn", tag, e), 8'(icn), 8'(tbl[i].icn));
          check($sformatf("%s e%0d per", tag, e), 8'(per), 8'(tbl[i].per));
          check($sformatf("%s e%0d rdy", tag, e), 8'(rdy), 8'(tbl[i].rdy));
          check($sformatf("%s e%0d cause", tag, e), 8'(cause), 8'(tbl[i].cause));
        end
    end
    tbl.delete();
  endtask

  task automatic set_idle();
    ext_resetn = 1'b1; aux_resetn = 1'b1; dcm_locked = 1'b1;
    sw_reset = 1'b0; cause_clr = 1'b0;
  endtask

  // Hold aresetn low, check reset values, release between clock edges.
  task automatic por();
    aresetn = 1'b0;
    set_idle();
    repeat (3) @(posedge clk);
    #1;
    check("reset icn", 8'(icn), 8'h00);
    check("reset per", 8'(per), 8'h00);
    check("reset rdy", 8'(rdy), 8'h00);
    check("reset cause", 8'(cause), 8'h10);
    model_reset();
    @(negedge clk);
    aresetn = 1'b1;
    edge_cnt = 0;
  endtask

  task automatic add_power_on_rows(int last);
    add(17, 5'b11100, 3'b000, 0, 0, 5'b10000);
    add(18, 5'b11100, 3'b001, 0, 0, 5'b10000);
    add(21, 5'b11100, 3'b001, 0, 0, 5'b10000);
    add(22, 5'b11100, 3'b011, 0, 0, 5'b10000);
    if (last >= 30) begin
      add(26, 5'b11100, 3'b111, 0, 0, 5'b10000);
      add(29, 5'b11100, 3'b111, 0, 0, 5'b10000);
      add(30, 5'b11100, 3'b111, 1, 1, 5'b10000);
    end
  endtask

  // ---------------- main ----------------
  initial begin
    aresetn = 1'b0;
    set_idle();
    model_reset();

    // Power-on, then a software reset pulse in RUN at edge 40.
    por();
    add(1, 5'b11100, 3'b000, 0, 0, 5'b10000);
    add_power_on_rows(30);
    add(40, 5'b11110, 3'b000, 0, 0, 5'b11000);
    add(41, 5'b11100, 3'b000, 0, 0, 5'b11000);
    add(55, 5'b11100, 3'b000, 0, 0, 5'b11000);
    add(56, 5'b11100, 3'b001, 0, 0, 5'b11000);
    add(60, 5'b11100, 3'b011, 0, 0, 5'b11000);
    add(64, 5'b11100, 3'b111, 0, 0, 5'b11000);
    add(67, 5'b11100, 3'b111, 0, 0, 5'b11000);
    add(68, 5'b11100, 3'b111, 1, 1, 5'b11000);
    run_tbl("sw", 70);

    // ext_resetn low before edge 21, high before edge 25. Seen at 23;
    // the last triggering edge is 26, so edges 27..42 are the 16 quiet
    // edges and re-release starts at 42.
    por();
    add(18, 5'b11100, 3'b001, 0, 0, 5'b10000);
    add(21, 5'b01100, 3'b001, 0, 0, 5'b10000);
    add(22, 5'b01100, 3'b011, 0, 0, 5'b10000);
    add(23, 5'b01100, 3'b000, 0, 0, 5'b10001);
    add(25, 5'b11100, 3'b000, 0, 0, 5'b10001);
    add(26, 5'b11100, 3'b000, 0, 0, 5'b10001);
    add(41, 5'b11100, 3'b000, 0, 0, 5'b10001);
    add(42, 5'b11100, 3'b001, 0, 0, 5'b10001);
    add(46, 5'b11100, 3'b011, 0, 0, 5'b10001);
    add(50, 5'b11100, 3'b111, 0, 0, 5'b10001);
    add(53, 5'b11100, 3'b111, 0, 0, 5'b10001);
    add(54, 5'b11100, 3'b111, 1, 1, 5'b10001);
    run_tbl("ext", 56);

    // dcm_locked dropped for one cycle every 10 cycles: never releases.
    por();
    for (int e = 5; e <= 75; e += 10) begin
      add(e,     5'b11000, 3'b000, 0, 0, (e == 5) ? 5'b10000 : 5'b10100);
      add(e + 1, 5'b11100, 3'b000, 0, 0, (e == 5) ? 5'b10000 : 5'b10100);
      add(e + 2, 5'b11100, 3'b000, 0, 0, 5'b10100);
    end
    add(80, 5'b11100, 3'b000, 0, 0, 5'b10100);
    run_tbl("dcm", 80);

    // cause_clr on the same edge as an aux-induced trigger (edge 37),
    // then a plain clear with no source active.
    por();
    add_power_on_rows(30);
    add(35, 5'b10100, 3'b111, 1, 1, 5'b10000);
    add(36, 5'b10100, 3'b111, 1, 1, 5'b10000);
    add(37, 5'b10101, 3'b000, 0, 0, 5'b00010);
    add(38, 5'b10100, 3'b000, 0, 0, 5'b00010);
    add(39, 5'b11100, 3'b000, 0, 0, 5'b00010);
    add(44, 5'b11101, 3'b000, 0, 0, 5'b00000);
    add(45, 5'b11100, 3'b000, 0, 0, 5'b00000);
    run_tbl("clr", 45);

    // aresetn asserted in the middle of RELEASE.
    por();
    add_power_on_rows(24);
    add(24, 5'b11100, 3'b011, 0, 0, 5'b10000);
    run_tbl("por_mid_pre", 24);
    aresetn = 1'b0;
    #1;
    check("por_mid async icn", 8'(icn), 8'h00);
    check("por_mid async per", 8'(per), 8'h00);
    check("por_mid async rdy", 8'(rdy), 8'h00);
    check("por_mid async cause", 8'(cause), 8'h10);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    edge_cnt = 0;
    add(1, 5'b11100, 3'b000, 0, 0, 5'b10000);
    add_power_on_rows(30);
    run_tbl("por_mid", 32);

    // Randomised sources against the model.
    por();
    for (int n = 0; n < 1500; n++) begin
      ext_resetn = ($urandom_range(0, 999) >= 6);
      aux_resetn = ($urandom_range(0, 999) >= 6);
      dcm_locked = ($urandom_range(0, 999) >= 6);
      sw_reset   = ($urandom_range(0, 999) < 4);
      cause_clr  = ($urandom_range(0, 99) < 3);
      do_edge();
    end
    set_idle();
    for (int n = 0; n < 40; n++) do_edge();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
